// File: rtl/video_out_if.sv
// video_out_if: Wishbone classic read-master bundle for the video_out pixel fetcher.
//   ADR_O  [31:0]  read address              (master -> slave)
//   DAT_I  [31:0]  read data                 (slave  -> master)
//   CYC_O, STB_O   cycle and strobe          (master -> slave)
//   WE_O           write enable, always 0    (master -> slave)
//   SEL_O  [3:0]   byte selects, always 4'hF (master -> slave)
//   ACK_I, ERR_I   normal / error terminate  (slave  -> master)
interface video_out_if;
    logic [31:0] ADR_O;
    logic [31:0] DAT_I;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [3:0]  SEL_O;
    logic        ACK_I;
    logic        ERR_I;
    modport master (output ADR_O, CYC_O, STB_O, WE_O, SEL_O, input DAT_I, ACK_I, ERR_I);
    modport slave  (input ADR_O, CYC_O, STB_O, WE_O, SEL_O, output DAT_I, ACK_I, ERR_I);
endinterface

// File: rtl/video_out.sv
// video_out: raster timing generator fed by a Wishbone-fetched 64-byte pixel FIFO.
//   p_clk, p_resetn     clock, asynchronous active-low reset
//   pix_en              pixel-slot strobe; raster timing only advances on it
//   frame_base[31:0]    4-byte aligned byte address of the frame
//   base_valid          frame_base valid; enables fetching and video output
//   line_valid          active-pixel qualifier (registered)
//   frame_valid         active-frame qualifier (registered)
//   pixel_out[7:0]      pixel byte, 00 outside active slots and on underrun
//   irq                 sticky underrun flag
//   p_wb                Wishbone read master (video_out_if.master)
// Optional feature: define VIDEO_OUT_UNDERRUN_IRQ_EN to make irq latch the first
// underrun; otherwise irq is tied low.
module video_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic        p_clk,
    input  logic        p_resetn,
    input  logic        pix_en,
    input  logic [31:0] frame_base,
    input  logic        base_valid,
    output logic        line_valid,
    output logic        frame_valid,
    output logic [7:0]  pixel_out,
    output logic        irq,
    video_out_if.master p_wb
);
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [31:0] FRAME_BYTES = 32'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, WAIT_ACK} state_t;

    state_t        state, state_nxt;
    logic [2:0]    beat;
    logic [31:0]   addr, fetched, word;
    logic          drop, started;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [6:0]    count;
    logic [5:0]    wr_ptr, rd_ptr;
    logic [7:0]    mem [64];
    logic          term, push, flush, active, pop, h_last;

    assign term   = state == WAIT_ACK && (p_wb.ACK_I || p_wb.ERR_I);
    assign h_last = h == HW'(H_TOTAL - 1);
    // Last slot of the last active line: the next slot starts vertical blanking.
    assign flush  = started && pix_en && h_last && v == VW'(V_ACTIVE - 1);
    // A beat that was in flight when the FIFO was flushed belongs to the old frame.
    assign push   = term && !drop && !flush;
    assign active = v < VW'(V_ACTIVE) && h < HW'(H_ACTIVE);
    assign pop    = started && base_valid && pix_en && active && count != 7'd0;
    assign word   = p_wb.ERR_I ? 32'h0000_0000 : p_wb.DAT_I;

    assign p_wb.ADR_O = addr;
    assign p_wb.CYC_O = state == REQ || state == WAIT_ACK;
    assign p_wb.STB_O = state == WAIT_ACK;
    assign p_wb.WE_O  = 1'b0;
    assign p_wb.SEL_O = 4'hF;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = base_valid ? WAIT_SPACE : IDLE;
            WAIT_SPACE: state_nxt = !base_valid ? IDLE :
                                    (count <= 7'd32 && fetched < FRAME_BYTES) ? REQ : WAIT_SPACE;
            REQ:        state_nxt = WAIT_ACK;
            WAIT_ACK:   state_nxt = !term ? WAIT_ACK : beat == 3'd7 ? WAIT_SPACE : REQ;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state   <= IDLE;
            beat    <= 3'd0;
            addr    <= 32'd0;
            fetched <= 32'd0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            beat    <= term ? beat + 3'd1 : beat;
            addr    <= (state == IDLE || flush) ? frame_base : push ? addr + 32'd4 : addr;
            fetched <= (state == IDLE || flush) ? 32'd0 : push ? fetched + 32'd4 : fetched;
            drop    <= state == WAIT_ACK && !term && (drop || flush);
        end
    end

    // Words land little-endian; wr_ptr stays 4-aligned so a word never straddles the wrap.
    always_ff @(posedge p_clk) begin
        if (push) begin
            mem[wr_ptr]        <= word[7:0];
            mem[wr_ptr + 6'd1] <= word[15:8];
            mem[wr_ptr + 6'd2] <= word[23:16];
            mem[wr_ptr + 6'd3] <= word[31:24];
        end
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            count       <= 7'd0;
            wr_ptr      <= 6'd0;
            rd_ptr      <= 6'd0;
            started     <= 1'b0;
            h           <= '0;
            v           <= '0;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            pixel_out   <= 8'h00;
        end else begin
            count   <= (state == IDLE || flush) ? 7'd0 : count + (push ? 7'd4 : 7'd0) - (pop ? 7'd1 : 7'd0);
            wr_ptr  <= (state == IDLE || flush) ? 6'd0 : wr_ptr + (push ? 6'd4 : 6'd0);
            rd_ptr  <= (state == IDLE || flush) ? 6'd0 : rd_ptr + (pop ? 6'd1 : 6'd0);
            // Raster stays parked at (0,0) until the first block of the frame is buffered.
            started <= state != IDLE && (started || fetched >= 32'd32);
            if (!started) begin
                h <= '0;
                v <= '0;
            end else if (pix_en) begin
                h <= h_last ? '0 : h + HW'(1);
                v <= !h_last ? v : v == VW'(V_TOTAL - 1) ? '0 : v + VW'(1);
            end
            if (!started || !base_valid) begin
                line_valid  <= 1'b0;
                frame_valid <= 1'b0;
                pixel_out   <= 8'h00;
            end else if (pix_en) begin
                frame_valid <= v < VW'(V_ACTIVE);
                line_valid  <= active;
                pixel_out   <= pop ? mem[rd_ptr] : 8'h00;
            end
        end
    end

`ifdef VIDEO_OUT_UNDERRUN_IRQ_EN
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) irq <= 1'b0;
        else           irq <= irq || (started && base_valid && pix_en && active && count == 7'd0);
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_video_out.sv
// tb_video_out: directed checks of video_out with an 8x2 active / 12x3 total raster.
module tb_video_out;
    localparam logic [31:0] BASE = 32'h4100_0000;
`ifdef VIDEO_OUT_UNDERRUN_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        pix_en = 1'b1;
    logic [31:0] frame_base = BASE;
    logic        base_valid = 1'b0;
    logic        line_valid, frame_valid, irq;
    logic [7:0]  pixel_out;
    logic        ack_en = 1'b1;
    logic [31:0] err_adr = 32'hFFFF_FFFF;
    logic [31:0] ram [16];
    logic        hit;
    int          total = 0;
    int          bad = 0;

    video_out_if wb();

    video_out #(.H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(2), .V_BLANK(1)) dut (
        .p_clk(p_clk), .p_resetn(p_resetn), .pix_en(pix_en), .frame_base(frame_base),
        .base_valid(base_valid), .line_valid(line_valid), .frame_valid(frame_valid),
        .pixel_out(pixel_out), .irq(irq), .p_wb(wb)
    );

    always #5 p_clk = ~p_clk;

    // Zero-wait-state RAM slave.
    always_comb begin
        hit      = wb.CYC_O && wb.STB_O && ack_en;
        wb.ERR_I = hit && wb.ADR_O == err_adr;
        wb.ACK_I = hit && wb.ADR_O != err_adr;
        wb.DAT_I = ram[wb.ADR_O[5:2]];
    end

    function automatic logic [7:0] exp_byte(input int n);
        return n < 4 ? 8'(17 * (n + 1)) : 8'(80 + n);
    endfunction

    task automatic do_reset();
        p_resetn = 1'b0; base_valid = 1'b0; pix_en = 1'b1; ack_en = 1'b1;
        err_adr = 32'hFFFF_FFFF; frame_base = BASE;
        repeat (2) @(posedge p_clk);
        #1 p_resetn = 1'b1;
    endtask

    // Prefill, optionally cut the bus afterwards, and stop on the first active slot.
    task automatic start_frame(input logic stop_ack, input logic [31:0] eadr);
        int k;
        do_reset();
        err_adr = eadr;
        base_valid = 1'b1;
        k = 0;
        for (int c = 0; c < 80 && k < 8; c++) begin
            @(posedge p_clk); #1;
            if (hit) k++;
        end
        @(posedge p_clk); #1;
        if (stop_ack) ack_en = 1'b0;
        for (int c = 0; c < 40 && !line_valid; c++) begin
            @(posedge p_clk); #1;
        end
        total++;
        if (line_valid !== 1'b1) begin bad++; $display("FAIL start_timeout: line_valid=%b want 1", line_valid); end
    endtask

    task automatic test_reset();
        p_resetn = 1'b0; base_valid = 1'b1;
        @(posedge p_clk); #1;
        total++;
        if ({line_valid, frame_valid, irq, wb.CYC_O, wb.STB_O, wb.WE_O} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 000000", {line_valid, frame_valid, irq, wb.CYC_O, wb.STB_O, wb.WE_O});
        end
        total++;
        if (pixel_out !== 8'h00) begin bad++; $display("FAIL reset_pixel: got %h want 00", pixel_out); end
        total++;
        if (wb.ADR_O !== 32'h0) begin bad++; $display("FAIL reset_adr: got %h want 00000000", wb.ADR_O); end
        total++;
        if (wb.SEL_O !== 4'hF) begin bad++; $display("FAIL reset_sel: got %h want f", wb.SEL_O); end
        base_valid = 1'b0;
    endtask

    task automatic test_prefill();
        int k;
        logic cyc_checked;
        do_reset();
        base_valid = 1'b1;
        k = 0;
        cyc_checked = 1'b0;
        for (int c = 0; c < 60 && !line_valid; c++) begin
            @(posedge p_clk); #1;
            if (hit) begin
                total++;
                if (wb.ADR_O !== BASE + 32'(4 * k)) begin
                    bad++; $display("FAIL prefill_adr[%0d]: got %h want %h", k, wb.ADR_O, BASE + 32'(4 * k));
                end
                k++;
            end else if (k == 8 && !cyc_checked) begin
                cyc_checked = 1'b1;
                total++;
                if (wb.CYC_O !== 1'b0) begin bad++; $display("FAIL prefill_cyc_drop: got %b want 0", wb.CYC_O); end
            end
        end
        total++;
        if (k !== 8) begin bad++; $display("FAIL prefill_beats: got %0d want 8", k); end
        total++;
        if (line_valid !== 1'b1) begin bad++; $display("FAIL prefill_first_pixel: line_valid=%b want 1", line_valid); end
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin @(posedge p_clk); #1; end
            total++;
            if (pixel_out !== exp_byte(j)) begin
                bad++; $display("FAIL order[%0d]: got %h want %h", j, pixel_out, exp_byte(j));
            end
        end
    endtask

    task automatic test_wrap();
        int l, c, fv_low;
        logic elv, efv;
        logic [7:0] ep;
        start_frame(1'b0, 32'hFFFF_FFFF);
        fv_low = 0;
        for (int i = 0; i < 72; i++) begin
            if (i > 0) begin @(posedge p_clk); #1; end
            l = (i / 12) % 3; c = i % 12;
            efv = l < 2; elv = efv && c < 8;
            ep = elv ? exp_byte(l * 8 + c) : 8'h00;
            total++;
            if ({line_valid, frame_valid} !== {elv, efv}) begin
                bad++; $display("FAIL wrap_valid[%0d]: got lv=%b fv=%b want lv=%b fv=%b", i, line_valid, frame_valid, elv, efv);
            end
            total++;
            if (pixel_out !== ep) begin bad++; $display("FAIL wrap_pixel[%0d]: got %h want %h", i, pixel_out, ep); end
            if (frame_valid === 1'b0) fv_low++;
            if (i == 22) begin
                total++;
                if (wb.ADR_O !== BASE + 32'h20) begin bad++; $display("FAIL wrap_adr_before: got %h want %h", wb.ADR_O, BASE + 32'h20); end
            end
            if (i == 23) begin
                total++;
                if (wb.ADR_O !== BASE) begin bad++; $display("FAIL wrap_adr_reload: got %h want %h", wb.ADR_O, BASE); end
            end
            if (i % 36 == 35) begin
                total++;
                if (fv_low !== 12) begin bad++; $display("FAIL wrap_fv_low[%0d]: got %0d want 12", i, fv_low); end
                fv_low = 0;
            end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL wrap_irq: got %b want 0", irq); end
    endtask

    task automatic test_disable();
        int acks;
        base_valid = 1'b0;
        acks = 0;
        @(posedge p_clk); #1;
        total++;
        if ({line_valid, frame_valid} !== 2'b00) begin
            bad++; $display("FAIL disable_valid: got %b want 00", {line_valid, frame_valid});
        end
        if (hit) acks++;
        for (int c = 0; c < 40; c++) begin
            @(posedge p_clk); #1;
            if (hit) acks++;
        end
        total++;
        if (acks == 0) begin bad++; $display("FAIL disable_block_finish: got %0d acks want >0", acks); end
        total++;
        if ({wb.CYC_O, line_valid, frame_valid} !== 3'b000) begin
            bad++; $display("FAIL disable_idle: got %b want 000", {wb.CYC_O, line_valid, frame_valid});
        end
    endtask

    task automatic test_err();
        int l, c, n;
        logic elv;
        logic [7:0] ep;
        start_frame(1'b0, BASE + 32'h8);
        for (int i = 0; i < 24; i++) begin
            if (i > 0) begin @(posedge p_clk); #1; end
            l = i / 12; c = i % 12; n = l * 8 + c;
            elv = c < 8;
            ep = !elv ? 8'h00 : (n >= 8 && n < 12) ? 8'h00 : exp_byte(n);
            total++;
            if (line_valid !== elv || pixel_out !== ep) begin
                bad++; $display("FAIL err_pixel[%0d]: got lv=%b px=%h want lv=%b px=%h", i, line_valid, pixel_out, elv, ep);
            end
        end
    endtask

    task automatic test_underrun();
        int l, c;
        logic elv, efv;
        logic [7:0] ep;
        start_frame(1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 72; i++) begin
            if (i > 0) begin @(posedge p_clk); #1; end
            l = (i / 12) % 3; c = i % 12;
            efv = l < 2; elv = efv && c < 8;
            ep = (elv && i < 36) ? exp_byte(l * 8 + c) : 8'h00;
            total++;
            if ({line_valid, frame_valid, pixel_out} !== {elv, efv, ep}) begin
                bad++; $display("FAIL underrun_slot[%0d]: got lv=%b fv=%b px=%h want lv=%b fv=%b px=%h",
                                i, line_valid, frame_valid, pixel_out, elv, efv, ep);
            end
            if (i == 35) begin
                total++;
                if (irq !== 1'b0) begin bad++; $display("FAIL underrun_irq_early: got %b want 0", irq); end
            end
        end
        total++;
        if (irq !== IRQ_EXP) begin bad++; $display("FAIL underrun_irq: got %b want %b", irq, IRQ_EXP); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_en = 1'b0;
        base_valid = 1'b1;
        for (int c = 0; c < 10 && !wb.STB_O; c++) begin
            @(posedge p_clk); #1;
        end
        total++;
        if (wb.STB_O !== 1'b1) begin bad++; $display("FAIL rstmid_wait_ack: stb=%b want 1", wb.STB_O); end
        #2 p_resetn = 1'b0;
        #1;
        total++;
        if ({wb.CYC_O, wb.STB_O} !== 2'b00 || wb.ADR_O !== 32'h0) begin
            bad++; $display("FAIL rstmid_async: got cyc=%b stb=%b adr=%h want 0 0 00000000", wb.CYC_O, wb.STB_O, wb.ADR_O);
        end
        ack_en = 1'b1;
        @(posedge p_clk); #1;
        total++;
        if (wb.CYC_O !== 1'b0) begin bad++; $display("FAIL rstmid_held: cyc=%b want 0", wb.CYC_O); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            ram[i] = {exp_byte(4 * i + 3), exp_byte(4 * i + 2), exp_byte(4 * i + 1), exp_byte(4 * i)};
        test_reset();
        test_prefill();
        test_wrap();
        test_disable();
        test_err();
        test_underrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
